// File: rtl/demux_4_hs.sv
// demux_4_hs: 1-to-4 valid/ready demultiplexer with a one-entry holding
// register and a per-channel delivered-word counter.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_EMPTY | holding register empty; upstream may load a word when en=1
// S_FULL  | word held in buf; presented on channel buf_sel until drained
module demux_4_hs #(
  parameter int WIDTH   = 3,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               clr,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [1:0]         in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   y0,
  output logic [WIDTH-1:0]   y1,
  output logic [WIDTH-1:0]   y2,
  output logic [WIDTH-1:0]   y3,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1,
  output logic [COUNT_W-1:0] cnt2,
  output logic [COUNT_W-1:0] cnt3
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  localparam logic [COUNT_W-1:0] CNT_ONE = COUNT_W'(1);

  state_t             r_state;
  logic [WIDTH-1:0]   r_buf_data;
  logic [1:0]         r_buf_sel;
  logic [COUNT_W-1:0] r_cnt [4];

  logic w_full;
  logic w_sink_ready;
  logic w_drain;
  logic w_in_ready;
  logic w_accept;

  assign w_full       = (r_state == S_FULL);
  assign w_sink_ready = out_ready[r_buf_sel];
  assign w_drain      = w_full && w_sink_ready;
  // rst_n gating keeps in_ready low for the whole reset assertion; no path from in_valid
  assign w_in_ready   = rst_n && en && (!w_full || w_sink_ready);
  assign w_accept     = in_valid && w_in_ready;

  assign in_ready = w_in_ready;

  // Holding-register FSM: load on accept, reload without a bubble when draining
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_EMPTY;
      r_buf_data <= '0;
      r_buf_sel  <= '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_accept) begin
            r_state    <= S_FULL;
            r_buf_data <= in_data;
            r_buf_sel  <= in_sel;
          end
        end
        S_FULL: begin
          if (w_accept) begin
            r_buf_data <= in_data;
            r_buf_sel  <= in_sel;
          end else if (w_drain) begin
            r_state <= S_EMPTY;
          end
        end
        default: r_state <= S_EMPTY;
      endcase
    end
  end

  // Delivered-word counters; clr wins over an increment in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (clr) begin
          r_cnt[i] <= '0;
        end else if (w_drain && (r_buf_sel == 2'(i))) begin
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Steer the held word to its channel; unselected channels read zero
  always_comb begin
    out_valid = 4'b0000;
    y0 = '0;
    y1 = '0;
    y2 = '0;
    y3 = '0;
    if (w_full) begin
      out_valid[r_buf_sel] = 1'b1;
      case (r_buf_sel)
        2'd0:    y0 = r_buf_data;
        2'd1:    y1 = r_buf_data;
        2'd2:    y2 = r_buf_data;
        default: y3 = r_buf_data;
      endcase
    end
  end

  assign cnt0 = r_cnt[0];
  assign cnt1 = r_cnt[1];
  assign cnt2 = r_cnt[2];
  assign cnt3 = r_cnt[3];

endmodule

// File: tb/tb_demux_4_hs.sv
// tb_demux_4_hs: scoreboard bench for demux_4_hs. The monitor keeps a
// queue of accepted words (at most one outstanding) plus expected counter
// values, and checks every DUT output on each falling edge.
module tb_demux_4_hs;
  localparam int W  = 3;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          clr = 1'b0;
  logic [W-1:0]  in_data = '0;
  logic [1:0]    in_sel = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  y0, y1, y2, y3;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready = 4'b0000;
  logic [CW-1:0] cnt0, cnt1, cnt2, cnt3;

  demux_4_hs #(.WIDTH(W), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(in_ready),
    .y0(y0), .y1(y1), .y2(y2), .y3(y3),
    .out_valid(out_valid), .out_ready(out_ready),
    .cnt0(cnt0), .cnt1(cnt1), .cnt2(cnt2), .cnt3(cnt3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]   sel;
    logic [W-1:0] data;
  } item_t;

  item_t q[$];
  int    exp_cnt[4];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_delivered = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model + monitor: compare outputs against the model, then advance
  // the model with the inputs that the coming rising edge will see.
  logic [3:0]   m_ev;
  logic [W-1:0] m_ey [4];
  logic         m_eir;
  logic [1:0]   m_s;
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
    end
    m_ev = 4'b0000;
    for (int i = 0; i < 4; i++) m_ey[i] = '0;
    if (q.size() > 0) begin
      m_ev[q[0].sel]   = 1'b1;
      m_ey[q[0].sel]   = q[0].data;
    end
    m_eir = rst_n && en && ((q.size() == 0) || out_ready[q[0].sel]);

    chk("out_valid", 32'(out_valid), 32'(m_ev));
    chk("y0", 32'(y0), 32'(m_ey[0]));
    chk("y1", 32'(y1), 32'(m_ey[1]));
    chk("y2", 32'(y2), 32'(m_ey[2]));
    chk("y3", 32'(y3), 32'(m_ey[3]));
    chk("in_ready", 32'(in_ready), 32'(m_eir));
    chk("cnt0", 32'(cnt0), 32'(exp_cnt[0]));
    chk("cnt1", 32'(cnt1), 32'(exp_cnt[1]));
    chk("cnt2", 32'(cnt2), 32'(exp_cnt[2]));
    chk("cnt3", 32'(cnt3), 32'(exp_cnt[3]));

    if (rst_n) begin
      if ((q.size() > 0) && out_ready[q[0].sel]) begin
        m_s = q[0].sel;
        void'(q.pop_front());
        n_delivered++;
        exp_cnt[m_s] = (exp_cnt[m_s] + 1) % (1 << CW);
      end
      if (clr) for (int i = 0; i < 4; i++) exp_cnt[i] = 0;
      if (in_valid && m_eir) q.push_back('{sel: in_sel, data: in_data});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] s, input logic [W-1:0] d);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
  endtask

  logic [W-1:0] stream_data [4];
  logic         hold;

  initial begin
    stream_data[0] = 3'b101; stream_data[1] = 3'b010;
    stream_data[2] = 3'b111; stream_data[3] = 3'b001;

    // Reset and idle
    en = 1'b1; out_ready = 4'b1111;
    repeat (3) step();
    rst_n = 1'b1;
    #1 chk("idle_in_ready", 32'(in_ready), 32'd1);
    step();

    // Streaming across all four channels on consecutive cycles
    for (int i = 0; i < 4; i++) begin
      send(2'(i), stream_data[i]);
      #1 chk("stream_in_ready", 32'(in_ready), 32'd1);
      step();
      if (i > 0) chk("stream_onehot", 32'(out_valid), 32'(4'b0001 << i));
    end
    in_valid = 1'b0;
    step(); step();
    chk("stream_cnt0", 32'(cnt0), 32'd1);
    chk("stream_cnt3", 32'(cnt3), 32'd1);

    // Backpressure on channel 2
    out_ready = 4'b1011;
    send(2'd2, 3'b110);
    step();
    send(2'd0, 3'b011);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_y2", 32'(y2), 32'(3'b110));
      step();
    end
    out_ready = 4'b1111;
    #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_cnt2", 32'(cnt2), 32'd2);
    chk("bp_reload", 32'(out_valid), 32'(4'b0001));
    step();

    // Enable low blocks acceptance, buffered word still drains
    en = 1'b0;
    send(2'd3, 3'b100);
    #1 chk("en_in_ready", 32'(in_ready), 32'd0);
    step(); step();
    chk("en_no_accept", 32'(out_valid), 32'd0);
    en = 1'b1; out_ready = 4'b0000;
    step();
    in_valid = 1'b0; en = 1'b0;
    step();
    chk("en_held", 32'(out_valid), 32'(4'b1000));
    out_ready = 4'b1111;
    step();
    chk("en_drained", 32'(out_valid), 32'd0);
    chk("en_cnt3", 32'(cnt3), 32'd2);
    en = 1'b1;

    // Counter wrap on channel 1
    clr = 1'b1; step(); clr = 1'b0;
    for (int i = 0; i < 256; i++) begin
      send(2'd1, 3'($urandom));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap_cnt1", 32'(cnt1), 32'd0);

    // clr together with a drain on channel 0
    send(2'd0, 3'b001); step();
    send(2'd0, 3'b010); step();
    in_valid = 1'b0;
    chk("clr_pre_cnt0", 32'(cnt0), 32'd1);
    clr = 1'b1; step(); clr = 1'b0;
    chk("clr_cnt0", 32'(cnt0), 32'd0);

    // Reset in the middle of a held word
    out_ready = 4'b0000;
    send(2'd1, 3'b111); step();
    in_valid = 1'b0; step();
    #2 rst_n = 1'b0;
    #1 chk("rst_async_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    step(); step();
    rst_n = 1'b1; out_ready = 4'b1111;
    repeat (3) step();
    chk("rst_no_delivery", 32'(cnt1), 32'd0);

    // Randomized traffic obeying the upstream stability rule
    hold = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = 3'($urandom);
        in_sel   = 2'($urandom);
      end
      en        = ($urandom_range(0, 7) != 0);
      clr       = ($urandom_range(0, 31) == 0);
      out_ready = 4'($urandom);
      #2 hold = in_valid && !in_ready;
      step();
    end
    in_valid = 1'b0; clr = 1'b0; en = 1'b1; out_ready = 4'b1111;
    repeat (3) step();
    chk("final_queue_empty", 32'(q.size()), 32'd0);
    if (n_delivered < 100) chk("delivered_volume", 32'(n_delivered), 32'd100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
